// File: rtl/arb_requester.sv
// arb_requester: requester side of the fixed-priority arbiter.
// Each of NCH independent channels accepts a burst job and raises REQ.
// While granted, it issues job_len+1 beats, then drops REQ for one
// RELEASE cycle so the arbiter can re-arbitrate.
module arb_requester #(
   parameter int NCH     = 4,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       job_valid,
   input  logic [NCH*LEN_W-1:0] job_len,
   output logic [NCH-1:0]       job_ready,
   output logic [NCH-1:0]       REQ,
   input  logic [NCH-1:0]       GNT,
   output logic [NCH-1:0]       beat_valid,
   output logic [NCH-1:0]       done,
   output logic [NCH-1:0]       starve,
   output logic [NCH-1:0]       gnt_err
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_XFER,
      S_REL
   } state_t;

   state_t            state_q [NCH];
   state_t            state_d [NCH];
   logic [LEN_W-1:0]  beat_q  [NCH];
   logic [LEN_W-1:0]  beat_d  [NCH];
   logic [WAIT_W-1:0] wait_q  [NCH];
   logic [WAIT_W-1:0] wait_d  [NCH];

   // starved_q remembers that the starve pulse for this wait was already sent,
   // since the saturated wait counter alone cannot tell first from later cycles.
   logic [NCH-1:0] starved_q, starved_d;
   logic [NCH-1:0] req_q, req_d;
   logic [NCH-1:0] done_q, done_d;
   logic [NCH-1:0] starve_q, starve_d;
   logic [NCH-1:0] gnt_err_q, gnt_err_d;

   // Per-channel next-state, counters, and registered-output next values.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i]   = state_q[i];
         beat_d[i]    = beat_q[i];
         wait_d[i]    = wait_q[i];
         starved_d[i] = starved_q[i];
         starve_d[i]  = 1'b0;

         job_ready[i]  = (state_q[i] == S_IDLE);
         beat_valid[i] = (state_q[i] == S_XFER) && GNT[i];

         case (state_q[i])
            S_IDLE: begin
               if (job_valid[i]) begin
                  beat_d[i]    = job_len[i*LEN_W +: LEN_W];
                  wait_d[i]    = '0;
                  starved_d[i] = 1'b0;
                  state_d[i]   = S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_q[i] != TMO) begin
                  wait_d[i] = wait_q[i] + WAIT_W'(1);
               end
               if ((wait_q[i] == TMO) && !starved_q[i]) begin
                  starve_d[i]  = 1'b1;
                  starved_d[i] = 1'b1;
               end
               if (GNT[i]) begin
                  state_d[i] = S_XFER;
               end
            end
            S_XFER: begin
               // Preempted cycles (GNT low) simply hold the counter.
               if (GNT[i]) begin
                  if (beat_q[i] == '0) begin
                     state_d[i] = S_REL;
                  end else begin
                     beat_d[i] = beat_q[i] - LEN_W'(1);
                  end
               end
            end
            S_REL: begin
               state_d[i] = S_IDLE;
            end
            default: begin
               state_d[i] = S_IDLE;
            end
         endcase

         req_d[i]     = (state_d[i] == S_WAIT) || (state_d[i] == S_XFER);
         done_d[i]    = (state_d[i] == S_REL);
         gnt_err_d[i] = GNT[i] && !req_q[i];
      end
   end

   // State and counter registers; reset aborts any burst without a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= S_IDLE;
            beat_q[i]  <= '0;
            wait_q[i]  <= '0;
         end
         starved_q <= '0;
         req_q     <= '0;
         done_q    <= '0;
         starve_q  <= '0;
         gnt_err_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            beat_q[i]  <= beat_d[i];
            wait_q[i]  <= wait_d[i];
         end
         starved_q <= starved_d;
         req_q     <= req_d;
         done_q    <= done_d;
         starve_q  <= starve_d;
         gnt_err_q <= gnt_err_d;
      end
   end

   assign REQ     = req_q;
   assign done    = done_q;
   assign starve  = starve_q;
   assign gnt_err = gnt_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester. Inputs change 1 time unit after the
// rising edge, outputs are observed on the falling edge. Expected done/starve/
// gnt_err events (kind, channel, cycle) are queued when stimulus is applied and
// compared against the events recorded from the DUT.
module tb_arb_requester;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  job_valid;
   logic [15:0] job_len;
   logic [3:0]  job_ready;
   logic [3:0]  REQ;
   logic [3:0]  GNT;
   logic [3:0]  beat_valid;
   logic [3:0]  done;
   logic [3:0]  starve;
   logic [3:0]  gnt_err;
   logic [3:0]  gnt_drv;
   logic        arb_en;

   // Fixed-priority arbiter model (channel 0 highest) or direct drive.
   assign GNT = arb_en ? (REQ & (~REQ + 4'd1)) : gnt_drv;

   arb_requester #(.NCH(4), .LEN_W(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .job_valid  (job_valid),
      .job_len    (job_len),
      .job_ready  (job_ready),
      .REQ        (REQ),
      .GNT        (GNT),
      .beat_valid (beat_valid),
      .done       (done),
      .starve     (starve),
      .gnt_err    (gnt_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;   // 0 done, 1 starve, 2 gnt_err
      logic [1:0]  ch;
      logic [15:0] cyc;
   } ev_t;

   ev_t exp_q[$];
   ev_t got_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc;
   int  beats[4];

   function automatic ev_t mk_ev(input int k, input int ch, input int c);
      ev_t r;
      r.kind = 2'(k);
      r.ch   = 2'(ch);
      r.cyc  = 16'(c);
      return r;
   endfunction

   task automatic start();
      @(posedge clk);
      #1;
      cyc = 0;
      for (int i = 0; i < 4; i++) beats[i] = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic obs();
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
         if (beat_valid[ch]) beats[ch]++;
         if (done[ch])    got_q.push_back(mk_ev(0, ch, cyc));
         if (starve[ch])  got_q.push_back(mk_ev(1, ch, cyc));
         if (gnt_err[ch]) got_q.push_back(mk_ev(2, ch, cyc));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; job_valid = 4'h0; job_len = 16'h0; gnt_drv = 4'h0; arb_en = 1'b0;
      #2;
      reset = 1'b0;
      job_valid = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({REQ, done, starve, gnt_err} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: REQ/done/starve/gnt_err=%h required 0000", {REQ, done, starve, gnt_err});
         end
      end
      @(posedge clk);
      #1;
      job_valid = 4'h0;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (job_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_job_ready: got %b required 1111", job_ready);
      end
      @(negedge clk);
      n_checks++;
      if (REQ !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_no_accept: REQ=%b required 0000", REQ);
      end
   endtask

   task automatic test_single_burst();
      ev_t e, g;
      int bad_req = 0;
      start();
      job_valid = 4'b0001; job_len = 16'h0003;
      exp_q.push_back(mk_ev(0, 0, 8));
      obs();
      for (int c = 1; c <= 10; c++) begin
         tick();
         job_valid = 4'h0;
         if (cyc == 3) gnt_drv[0] = 1'b1;
         if (beats[0] >= 4) gnt_drv[0] = 1'b0;
         obs();
         if (cyc <= 7 && REQ[0] !== 1'b1) bad_req++;
         if (cyc == 8) begin
            n_checks++;
            if (REQ[0] !== 1'b0 || job_ready[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL single_release: REQ0=%b job_ready0=%b required 0 0", REQ[0], job_ready[0]);
            end
         end
         if (cyc == 9) begin
            n_checks++;
            if (job_ready[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL single_ready: job_ready0=%b required 1", job_ready[0]);
            end
         end
      end
      n_checks++;
      if (bad_req != 0) begin n_fail++; $display("FAIL single_req_high: %0d low cycles required 0", bad_req); end
      n_checks++;
      if (beats[0] != 4) begin n_fail++; $display("FAIL single_beats: got %0d required 4", beats[0]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL single_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL single_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL single_extra: %0d extra events, required 0", got_q.size()); end
   endtask

   task automatic test_preemption();
      ev_t e, g;
      int bad_req = 0;
      int gap_beats = 0;
      start();
      job_valid = 4'b0010; job_len = 16'h0050;
      exp_q.push_back(mk_ev(0, 1, 11));
      obs();
      for (int c = 1; c <= 13; c++) begin
         tick();
         job_valid = 4'h0;
         if (cyc == 1) gnt_drv[1] = 1'b1;
         if (cyc == 4) gnt_drv[1] = 1'b0;
         if (cyc == 7) gnt_drv[1] = 1'b1;
         if (beats[1] >= 6) gnt_drv[1] = 1'b0;
         obs();
         if (cyc <= 10 && REQ[1] !== 1'b1) bad_req++;
         if (cyc >= 4 && cyc <= 6 && beat_valid[1]) gap_beats++;
      end
      n_checks++;
      if (bad_req != 0) begin n_fail++; $display("FAIL preempt_req_high: %0d low cycles required 0", bad_req); end
      n_checks++;
      if (gap_beats != 0) begin n_fail++; $display("FAIL preempt_gap: %0d beats required 0", gap_beats); end
      n_checks++;
      if (beats[1] != 6) begin n_fail++; $display("FAIL preempt_beats: got %0d required 6", beats[1]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL preempt_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL preempt_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL preempt_extra: %0d extra events, required 0", got_q.size()); end
   endtask

   task automatic test_starvation();
      ev_t e, g;
      int bad_req = 0;
      start();
      job_valid = 4'b0100; job_len = 16'h0100;
      // REQ rises in cycle 1; starve 17 cycles later; grant at 21 -> 2 beats, done at 24
      exp_q.push_back(mk_ev(1, 2, 18));
      exp_q.push_back(mk_ev(0, 2, 24));
      obs();
      for (int c = 1; c <= 26; c++) begin
         tick();
         job_valid = 4'h0;
         if (cyc == 21) gnt_drv[2] = 1'b1;
         if (beats[2] >= 2) gnt_drv[2] = 1'b0;
         obs();
         if (cyc <= 23 && REQ[2] !== 1'b1) bad_req++;
      end
      n_checks++;
      if (bad_req != 0) begin n_fail++; $display("FAIL starve_req_high: %0d low cycles required 0", bad_req); end
      n_checks++;
      if (beats[2] != 2) begin n_fail++; $display("FAIL starve_beats: got %0d required 2", beats[2]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL starve_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL starve_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL starve_extra: %0d extra events, required 0", got_q.size()); end
   endtask

   task automatic test_arbiter();
      ev_t e, g;
      int overlap = 0;
      start();
      arb_en = 1'b1;
      job_valid = 4'hF; job_len = 16'h1111;
      // Priority order 0..3, each 2 beats + RELEASE -> done every 3 cycles
      for (int ch = 0; ch < 4; ch++) exp_q.push_back(mk_ev(0, ch, 4 + 3 * ch));
      obs();
      for (int c = 1; c <= 15; c++) begin
         tick();
         job_valid = 4'h0;
         obs();
         if ($countones(beat_valid) > 1) overlap++;
      end
      arb_en = 1'b0;
      n_checks++;
      if (overlap != 0) begin n_fail++; $display("FAIL arb_overlap: %0d cycles required 0", overlap); end
      for (int ch = 0; ch < 4; ch++) begin
         n_checks++;
         if (beats[ch] != 2) begin n_fail++; $display("FAIL arb_beats ch%0d: got %0d required 2", ch, beats[ch]); end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL arb_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL arb_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL arb_extra: %0d extra events (gnt_err?), required 0", got_q.size()); end
   endtask

   task automatic test_gnt_err();
      ev_t e, g;
      start();
      gnt_drv = 4'b1000;
      exp_q.push_back(mk_ev(2, 3, 1));
      obs();
      for (int c = 1; c <= 3; c++) begin
         tick();
         gnt_drv = 4'h0;
         obs();
      end
      n_checks++;
      if (beats[3] != 0) begin n_fail++; $display("FAIL gnt_err_beat: got %0d beats required 0", beats[3]); end
      n_checks++;
      if (REQ[3] !== 1'b0 || job_ready[3] !== 1'b1) begin
         n_fail++; $display("FAIL gnt_err_state: REQ3=%b job_ready3=%b required 0 1", REQ[3], job_ready[3]);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL gnt_err_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL gnt_err_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL gnt_err_extra: %0d extra events, required 0", got_q.size()); end
   endtask

   task automatic test_max_len();
      ev_t e, g;
      start();
      job_valid = 4'b0001; job_len = 16'h000F;
      exp_q.push_back(mk_ev(0, 0, 18));
      obs();
      for (int c = 1; c <= 20; c++) begin
         tick();
         job_valid = 4'h0;
         job_len = 16'h0002;   // must be ignored after accept
         if (cyc == 1) gnt_drv[0] = 1'b1;
         if (beats[0] >= 16) gnt_drv[0] = 1'b0;
         obs();
      end
      n_checks++;
      if (beats[0] != 16) begin n_fail++; $display("FAIL maxlen_beats: got %0d required 16", beats[0]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL maxlen_event: no event recorded, required kind %0d ch %0d cyc %0d", e.kind, e.ch, e.cyc);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL maxlen_event: got kind %0d ch %0d cyc %0d, required kind %0d ch %0d cyc %0d", g.kind, g.ch, g.cyc, e.kind, e.ch, e.cyc);
            end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL maxlen_extra: %0d extra events, required 0", got_q.size()); end
   endtask

   task automatic test_reset_mid_burst();
      start();
      job_valid = 4'b0010; job_len = 16'h0070;
      obs();
      for (int c = 1; c <= 4; c++) begin
         tick();
         job_valid = 4'h0;
         if (cyc == 1) gnt_drv[1] = 1'b1;
         obs();
      end
      n_checks++;
      if (beats[1] != 3) begin n_fail++; $display("FAIL midrst_pre_beats: got %0d required 3", beats[1]); end
      tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if (REQ !== 4'h0 || beat_valid !== 4'h0) begin
         n_fail++; $display("FAIL midrst_immediate: REQ=%b beat_valid=%b required 0000 0000", REQ, beat_valid);
      end
      gnt_drv = 4'h0;
      obs();
      tick(); obs();
      tick();
      reset = 1'b1;
      obs();
      n_checks++;
      if (job_ready !== 4'hF) begin n_fail++; $display("FAIL midrst_ready: got %b required 1111", job_ready); end
      tick(); obs();
      n_checks++;
      if (REQ !== 4'h0) begin n_fail++; $display("FAIL midrst_req: got %b required 0000", REQ); end
      n_checks++;
      if (got_q.size() != 0) begin
         n_fail++; $display("FAIL midrst_events: %0d events (done?), required 0", got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_preemption();
      test_starvation();
      test_arbiter();
      test_gnt_err();
      test_max_len();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
